// File: rtl/prime_trial_ctrl_pkg.sv
// Shared definitions for the trial-division primality controller.
// Build option: PRIME_TRIAL_CTRL_ODD_SKIP_EN. When it is defined, divisors run
// 2,3,5,7,... (only odd divisors after 2). When it is not defined, divisors run 2,3,4,5,...
package prime_trial_ctrl_pkg;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // First trial divisor, and the step from 2 to 3
   localparam int unsigned FIRST_DIVISOR = 2;
   localparam int unsigned STEP_UNIT     = 1;

   // Step used once the divisor has passed 2
`ifdef PRIME_TRIAL_CTRL_ODD_SKIP_EN
   localparam int unsigned STEP_AFTER_TWO = 2;
`else
   localparam int unsigned STEP_AFTER_TWO = 1;
`endif

   // Increment that follows the current divisor
   function automatic int unsigned divisor_step(input int unsigned d);
      return (d == FIRST_DIVISOR) ? STEP_UNIT : STEP_AFTER_TWO;
   endfunction

endpackage

// File: rtl/prime_trial_ctrl_if.sv
// Stream signals of the primality controller: candidate in, result out,
// and the request/response pair to the external divider.
// master = the controller, slave = the environment (source, sink, divider).
interface prime_trial_ctrl_if #(
   parameter int unsigned nbits = 16
);
   // candidate stream
   logic [nbits-1:0] in_n;
   logic             in_val;
   logic             in_rdy;
   // result stream
   logic             out_is_prime;
   logic [nbits-1:0] out_trials;
   logic             out_val;
   logic             out_rdy;
   // divider request / response
   logic [nbits-1:0] div_opa;
   logic [nbits-1:0] div_opb;
   logic             div_istream_val;
   logic             div_istream_rdy;
   logic [nbits-1:0] div_result;
   logic             div_ostream_val;
   logic             div_ostream_rdy;

   modport master (
      input  in_n, in_val, out_rdy, div_istream_rdy, div_result, div_ostream_val,
      output in_rdy, out_is_prime, out_trials, out_val,
             div_opa, div_opb, div_istream_val, div_ostream_rdy
   );

   modport slave (
      output in_n, in_val, out_rdy, div_istream_rdy, div_result, div_ostream_val,
      input  in_rdy, out_is_prime, out_trials, out_val,
             div_opa, div_opb, div_istream_val, div_ostream_rdy
   );
endinterface

// File: rtl/prime_trial_ctrl.sv
// Trial-division primality controller. It latches a candidate N and issues
// N mod d to an external divider for d = 2, 3, ... while d*d <= N. It stops
// at the first zero remainder. Build option PRIME_TRIAL_CTRL_ODD_SKIP_EN
// skips even divisors after 2. The result does not change; only the trial
// count does.
module prime_trial_ctrl
   import prime_trial_ctrl_pkg::*;
#(
   parameter int unsigned nbits = 16
) (
   input logic               clk,
   input logic               reset,
   prime_trial_ctrl_if.master bus
);

   localparam logic [nbits-1:0] W_TWO = nbits'(FIRST_DIVISOR);

   state_t r_state;
   state_t w_state_nxt;

   logic [nbits-1:0]   r_n;
   logic [nbits-1:0]   r_d;
   logic [nbits-1:0]   r_trials;
   logic               r_prime;

   logic [2*nbits-1:0] w_d_wide;
   logic [2*nbits-1:0] w_n_wide;
   logic [2*nbits-1:0] w_dsq;
   logic               w_n_small;
   logic               w_d_past_root;
   logic [nbits-1:0]   w_step;

   logic               w_in_rdy;
   logic               w_out_val;
   logic               w_req_val;
   logic               w_rsp_rdy;
   logic               w_in_fire;
   logic               w_req_fire;
   logic               w_rsp_fire;
   logic               w_out_fire;
   logic               w_rem_zero;

   // The square is computed at twice the operand width, so d*d never wraps.
   assign w_d_wide      = {{nbits{1'b0}}, r_d};
   assign w_n_wide      = {{nbits{1'b0}}, r_n};
   assign w_dsq         = w_d_wide * w_d_wide;
   assign w_n_small     = (r_n < W_TWO);
   assign w_d_past_root = (w_dsq > w_n_wide);
   assign w_step        = nbits'(divisor_step(int'(r_d)));
   assign w_rem_zero    = (bus.div_result == '0);

   // Each handshake qualifier is active in exactly one state.
   assign w_in_rdy   = (r_state == ST_IDLE);
   assign w_req_val  = (r_state == ST_ISSUE);
   assign w_rsp_rdy  = (r_state == ST_WAIT);
   assign w_out_val  = (r_state == ST_DONE);

   assign w_in_fire  = w_in_rdy  & bus.in_val;
   assign w_req_fire = w_req_val & bus.div_istream_rdy;
   assign w_rsp_fire = w_rsp_rdy & bus.div_ostream_val;
   assign w_out_fire = w_out_val & bus.out_rdy;

   assign bus.in_rdy          = w_in_rdy;
   assign bus.out_val         = w_out_val;
   assign bus.out_is_prime    = r_prime;
   assign bus.out_trials      = r_trials;
   assign bus.div_istream_val = w_req_val;
   assign bus.div_ostream_rdy = w_rsp_rdy;
   assign bus.div_opa         = r_n;
   assign bus.div_opb         = r_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state selection
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_in_fire) w_state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_n_small || w_d_past_root) w_state_nxt = ST_DONE;
            else                            w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (w_req_fire) w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_rsp_fire) w_state_nxt = w_rem_zero ? ST_DONE : ST_CHECK;
         end
         ST_DONE: begin
            if (w_out_fire) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Candidate, divisor, trial count and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_n      <= '0;
         r_d      <= '0;
         r_trials <= '0;
         r_prime  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_in_fire) begin
                  r_n      <= bus.in_n;
                  r_d      <= W_TWO;
                  r_trials <= '0;
                  r_prime  <= 1'b0;
               end
            end
            ST_CHECK: begin
               // Composite results leave r_prime at the 0 loaded on accept.
               if (!w_n_small && w_d_past_root) r_prime <= 1'b1;
            end
            ST_ISSUE: begin
               if (w_req_fire) r_trials <= r_trials + 1'b1;
            end
            ST_WAIT: begin
               if (w_rsp_fire && !w_rem_zero) r_d <= r_d + w_step;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prime_trial_ctrl.sv
// Self-checking bench for prime_trial_ctrl, with a one-deep divider model
// and a result scoreboard. Build option: PRIME_TRIAL_CTRL_ODD_SKIP_EN.
module tb_prime_trial_ctrl;

   localparam int unsigned NB = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   prime_trial_ctrl_if #(.nbits(NB)) bus ();

   prime_trial_ctrl #(.nbits(NB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NB-1:0] n;
      logic          prime;
      int unsigned   trials;
   } exp_t;
   exp_t sb[$];

   // ---------------- divider model: one request in flight, one-cycle response
   logic          dv_pending;
   logic          dv_stall;
   logic [NB-1:0] dv_res;
   int unsigned   req_seen;

   assign bus.div_istream_rdy = !dv_pending && !dv_stall;
   assign bus.div_ostream_val = dv_pending;
   assign bus.div_result      = dv_res;

   always @(posedge clk) begin
      if (reset) begin
         dv_pending <= 1'b0;
         dv_res     <= '0;
         req_seen   <= 0;
      end else if (bus.div_istream_val && bus.div_istream_rdy) begin
         dv_pending <= 1'b1;
         dv_res     <= (bus.div_opb == '0) ? '0 : (bus.div_opa % bus.div_opb);
         req_seen   <= req_seen + 1;
      end else if (bus.div_ostream_val && bus.div_ostream_rdy) begin
         dv_pending <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Request-side invariants, checked whenever a request is on offer
   always @(negedge clk) begin
      if (!reset && bus.div_istream_val === 1'b1) begin
         check("opb_ge_2", 32'(bus.div_opb >= 2), 32'd1);
         check("no_req_while_pending", 32'(dv_pending), 32'd0);
      end
   end

   // Reference trial-division model
   function automatic void ref_prime(input int unsigned n, output logic p, output int unsigned t);
      int unsigned d;
      d = 2;
      t = 0;
      p = 1'b0;
      if (n < 2) return;
      while (d * d <= n) begin
         t++;
         if (n % d == 0) return;
`ifdef PRIME_TRIAL_CTRL_ODD_SKIP_EN
         d = (d == 2) ? 3 : d + 2;
`else
         d = d + 1;
`endif
      end
      p = 1'b1;
   endfunction

   int unsigned req_base;

   // Called at a negedge: offer n, return at the negedge after the accept edge
   task automatic do_accept(input logic [NB-1:0] n);
      exp_t        e;
      int unsigned waited;
      waited = 0;
      while (bus.in_rdy !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (bus.in_rdy !== 1'b1) check("in_rdy_timeout", 32'(bus.in_rdy), 32'd1);
      e.n = n;
      ref_prime(int'(n), e.prime, e.trials);
      sb.push_back(e);
      req_base   = req_seen;
      bus.in_n   = n;
      bus.in_val = 1'b1;
      @(negedge clk);
      bus.in_val = 1'b0;
      bus.in_n   = NB'($urandom);   // must be ignored outside IDLE
   endtask

   // Wait for a result, score it, hold it for 'hold' cycles, then release it
   task automatic do_collect(input int unsigned hold, output int unsigned lat);
      exp_t          e;
      logic          p0;
      logic [NB-1:0] t0;
      logic          stable;
      lat = 1;
      while (bus.out_val !== 1'b1 && lat < 5000) begin
         @(negedge clk);
         lat++;
      end
      if (bus.out_val !== 1'b1) check("out_val_timeout", 32'(bus.out_val), 32'd1);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check("is_prime", 32'(bus.out_is_prime), 32'(e.prime));
         check("trials", 32'(bus.out_trials), e.trials);
         check("trials_vs_requests", 32'(bus.out_trials), req_seen - req_base);
      end
      if (hold > 0) begin
         bus.out_rdy = 1'b0;
         p0 = bus.out_is_prime;
         t0 = bus.out_trials;
         stable = 1'b1;
         for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            if (bus.out_val !== 1'b1 || bus.out_is_prime !== p0 ||
                bus.out_trials !== t0 || bus.in_rdy !== 1'b0) stable = 1'b0;
         end
         check("done_hold_stable", 32'(stable), 32'd1);
         bus.out_rdy = 1'b1;
      end
      @(negedge clk);
      check("idle_after_out", 32'({bus.in_rdy, bus.out_val}), 32'b10);
   endtask

   task automatic run(input logic [NB-1:0] n, input int unsigned hold, output int unsigned lat);
      do_accept(n);
      do_collect(hold, lat);
   endtask

   initial begin
      int unsigned lat;
      int unsigned waited;
      logic        ok;
      bus.in_n    = '0;
      bus.in_val  = 1'b0;
      bus.out_rdy = 1'b1;
      dv_stall    = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
      check("rst_out_val", 32'(bus.out_val), 32'd0);
      check("rst_req_val", 32'(bus.div_istream_val), 32'd0);
      check("rst_rsp_rdy", 32'(bus.div_ostream_rdy), 32'd0);
      check("rst_prime", 32'(bus.out_is_prime), 32'd0);
      check("rst_trials", 32'(bus.out_trials), 32'd0);
      check("rst_opa", 32'(bus.div_opa), 32'd0);
      check("rst_opb", 32'(bus.div_opb), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Small candidates and the minimum latency
      run(16'd2, 0, lat);
      check("lat_n2", lat, 32'd2);
      check("n2_trials_const", 32'(dut.r_trials), 32'd0);
      run(16'd3, 0, lat);
      check("lat_n3", lat, 32'd2);
      run(16'd0, 0, lat);
      run(16'd1, 0, lat);

      // Spec reference points
      run(16'd97, 0, lat);
      check("n97_prime_const", 32'(dut.r_prime), 32'd1);
`ifdef PRIME_TRIAL_CTRL_ODD_SKIP_EN
      check("n97_trials_const", 32'(dut.r_trials), 32'd5);
`else
      check("n97_trials_const", 32'(dut.r_trials), 32'd8);
`endif
      run(16'd91, 0, lat);
      check("n91_prime_const", 32'(dut.r_prime), 32'd0);
`ifdef PRIME_TRIAL_CTRL_ODD_SKIP_EN
      check("n91_trials_const", 32'(dut.r_trials), 32'd4);
`else
      check("n91_trials_const", 32'(dut.r_trials), 32'd6);
`endif

      // Divider back-pressure: the request must hold still
      dv_stall = 1'b1;
      do_accept(16'd4);
      waited = 0;
      while (bus.div_istream_val !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (bus.div_istream_val !== 1'b1 || bus.div_opa !== 16'd4 || bus.div_opb !== 16'd2) ok = 1'b0;
         @(negedge clk);
      end
      check("stall_req_stable", 32'(ok), 32'd1);
      dv_stall = 1'b0;
      do_collect(0, lat);
      check("n4_trials_const", 32'(dut.r_trials), 32'd1);

      // Consumer back-pressure in DONE
      run(16'd13, 10, lat);

      // Reset while waiting on the divider
      do_accept(16'd65521);
      waited = 0;
      while (bus.div_ostream_rdy !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("reached_wait", 32'(bus.div_ostream_rdy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
      check("mid_rst_quiet",
            32'({bus.out_val, bus.div_istream_val, bus.div_ostream_rdy, bus.out_is_prime}), 32'd0);
      check("mid_rst_trials", 32'(bus.out_trials), 32'd0);
      check("mid_rst_ops", 32'({bus.div_opa, bus.div_opb}), 32'd0);
      sb.delete();
      reset = 1'b0;
      @(negedge clk);
      run(16'd9, 0, lat);
      check("n9_trials_const", 32'(dut.r_trials), 32'd2);
      check("n9_prime_const", 32'(dut.r_prime), 32'd0);

      // Random candidates, with occasional consumer back-pressure
      for (int k = 0; k < 16; k++) begin
         run(NB'($urandom_range(0, 3000)), ((k % 5) == 0) ? 3 : 0, lat);
      end
      run(16'd65521, 0, lat);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Overall time limit so a stuck design still reaches a verdict
   initial begin
      #5000000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/prime_trial_ctrl.md
PRIME_TRIAL_CTRL -- requirements
Module: prime_trial_ctrl

Interface
REQ-001 Parameter: nbits, default 16, width of candidate, divisor and divider operands.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_n  input  nbits  candidate number to test.
REQ-005 in_val  input  1  candidate valid.
REQ-006 in_rdy  output  1  controller ready for a candidate.
REQ-007 out_is_prime  output  1  1 = candidate is prime.
REQ-008 out_trials  output  nbits  number of divider transactions issued for this candidate.
REQ-009 out_val  output  1  result valid.
REQ-010 out_rdy  input  1  consumer ready.
REQ-011 div_opa  output  nbits  dividend to divider (latched candidate).
REQ-012 div_opb  output  nbits  trial divisor to divider.
REQ-013 div_istream_val  output  1  divider request valid.
REQ-014 div_istream_rdy  input  1  divider accepts request.
REQ-015 div_result  input  nbits  divider response, equal to div_opa mod div_opb.
REQ-016 div_ostream_val  input  1  divider response valid.
REQ-017 div_ostream_rdy  output  1  controller accepts divider response.

Function
REQ-018 States SHALL be IDLE, CHECK, ISSUE, WAIT, DONE; handshake fires on a cycle where val and rdy are both 1.
REQ-019 IDLE: in_rdy=1; on in handshake latch N=in_n, d=2, trials=0, go to CHECK; otherwise stay.
REQ-020 CHECK (one cycle, no handshakes): N<2 -> DONE, prime=0; else d*d>N (computed at 2*nbits width, no overflow) -> DONE, prime=1; else -> ISSUE.
REQ-021 ISSUE: div_istream_val=1, div_opa=N, div_opb=d held stable until div_istream_rdy; on handshake trials+=1, go to WAIT.
REQ-022 WAIT: div_ostream_rdy=1; on response handshake: div_result==0 -> DONE, prime=0; else d+=step, go to CHECK.
REQ-023 DONE: out_val=1, out_is_prime and out_trials stable; on out handshake -> IDLE.
REQ-024 div_istream_val SHALL be 1 only in ISSUE; div_ostream_rdy only in WAIT; in_rdy only in IDLE; out_val only in DONE.
REQ-025 d SHALL never be 0 or 1 when presented on div_opb.
REQ-026 Exactly one divider request SHALL be outstanding at most; no request is issued while a response is pending.
REQ-027 Minimum latency accept-to-out_val for N in {2,3}: 2 cycles (IDLE->CHECK->DONE), zero divider transactions.
REQ-028 Inputs in_n changing while not in IDLE SHALL have no effect.

Reset
REQ-029 Reset SHALL force IDLE next cycle from any state, including mid-ISSUE/WAIT, abandoning the transaction.
REQ-030 During/after reset: in_rdy=1 (after first edge), out_val=0, div_istream_val=0, div_ostream_rdy=0, out_is_prime=0, out_trials=0, div_opa=0, div_opb=0.
REQ-031 Divider shares the same reset, so no stale response survives reset.

Configuration
REQ-032 Macro PRIME_TRIAL_CTRL_ODD_SKIP_EN: when defined, step=1 after d=2 then step=2 (divisors 2,3,5,7,...); when undefined, step=1 always (2,3,4,5,...).
REQ-033 is_prime result SHALL be identical in both configurations; only out_trials and latency differ.

Structure
REQ-034 Shared package SHALL hold state encoding constants (IDLE..DONE) and step constants; datapath widths derive from nbits.
REQ-035 No sub-module; divider instantiated alongside at top level, connected via div_* ports.

Verification
REQ-036 N=97, divider 1-cycle rdy -> is_prime=1; trials=8 (d=2..9) without macro, 5 (2,3,5,7,9) with macro.
REQ-037 N=91 -> is_prime=0 at d=7; trials=6 without macro, 4 with macro.
REQ-038 N=0, N=1 -> is_prime=0, trials=0, no div_istream_val asserted; N=2 -> is_prime=1, trials=0.
REQ-039 N=4 with div_istream_rdy held low 5 cycles -> div_opa=4/div_opb=2 stable throughout; then is_prime=0, trials=1.
REQ-040 out_rdy low 10 cycles in DONE -> out_val, out_is_prime, out_trials held, in_rdy=0; release -> IDLE next cycle.
REQ-041 Reset asserted in WAIT for N=65521 -> next cycle IDLE, all REQ-030 values; new N=9 then yields is_prime=0, trials=2 without macro.
